// File: rtl/rv32i_defs.sv
// Shared RV32I load/store definitions for the data-memory slice.
package rv32i_defs;

  localparam int unsigned WordBytes = 4;

  // funct3 width/sign codes for loads; stores reuse the low three codes.
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } mem_funct3_e;

  localparam mem_funct3_e SB = LB;
  localparam mem_funct3_e SH = LH;
  localparam mem_funct3_e SW = LW;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } lsu_state_e;

endpackage

// File: rtl/lsu_align_unit.sv
// Combinational lane alignment: store byte-enables/data shift, load
// lane selection with sign/zero extension, and width/alignment errors.
module lsu_align_unit
  import rv32i_defs::*;
(
  input  logic [2:0]           funct3_i,
  input  logic                 write_i,
  input  logic [1:0]           lane_i,
  input  logic [31:0]          wdata_i,
  input  logic [31:0]          rword_i,
  output logic [WordBytes-1:0] be_o,
  output logic [31:0]          wdata_o,
  output logic                 err_o,
  output logic [31:0]          rdata_o
);

  logic [31:0] rshift;

  // Decode legality and byte-enables from width code and byte lane.
  always_comb begin
    err_o = 1'b0;
    be_o  = '0;
    case (funct3_i)
      SB:      be_o = 4'b0001 << lane_i;
      SH:      if (lane_i[0]) err_o = 1'b1;
               else           be_o  = 4'b0011 << lane_i;
      SW:      if (lane_i != 2'b00) err_o = 1'b1;
               else                 be_o  = '1;
      LBU:     err_o = write_i;
      LHU:     err_o = write_i | lane_i[0];
      default: err_o = 1'b1;
    endcase
    if (err_o) be_o = '0;
  end

  // Store data is LSB-aligned on the port; move it up to its lane.
  always_comb begin
    wdata_o = wdata_i << {lane_i, 3'b000};
  end

  // Bring the addressed lane down to bit 0, then extend per width code.
  always_comb begin
    rshift  = rword_i >> {lane_i, 3'b000};
    rdata_o = '0;
    case (funct3_i)
      LB:      rdata_o = {{24{rshift[7]}}, rshift[7:0]};
      LH:      rdata_o = {{16{rshift[15]}}, rshift[15:0]};
      LW:      rdata_o = rshift;
      LBU:     rdata_o = {24'h000000, rshift[7:0]};
      LHU:     rdata_o = {16'h0000, rshift[15:0]};
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_data_memory.sv
// Word-organised RV32I data memory with valid/ready request port,
// READ_LATENCY-deep response pipeline and a post-reset clear sequencer.
module lsu_data_memory
  import rv32i_defs::*;
#(
  parameter int DATA_SIZE    = 32,
  parameter int BLOCK_SIZE   = 8,
  parameter int NUM_BLOCKS   = 256,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_SIZE    = $clog2(NUM_BLOCKS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [2:0]           req_funct3,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [DATA_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [DATA_SIZE-1:0] rsp_rdata,
  output logic                 rsp_error
);

  localparam int NumWords = NUM_BLOCKS / int'(WordBytes);
  localparam int IdxW     = ADDR_SIZE - 2;

  lsu_state_e          state_q, state_d;
  logic [IdxW-1:0]     clr_cnt_q, clr_cnt_d;
  logic                clear_we;

  logic [DATA_SIZE-1:0] mem_q [NumWords];

  logic                 accept;
  logic [IdxW-1:0]      word_idx;
  logic [1:0]           lane;
  logic [WordBytes-1:0] be;
  logic [DATA_SIZE-1:0] wdata_sh;
  logic [DATA_SIZE-1:0] load_ext;
  logic                 align_err;

  logic [READ_LATENCY-1:0] pv_q;
  logic [READ_LATENCY-1:0] pe_q;
  logic [DATA_SIZE-1:0]    pd_q [READ_LATENCY];

  assign accept   = req_valid & req_ready;
  assign word_idx = req_addr[ADDR_SIZE-1:2];
  assign lane     = req_addr[1:0];

  lsu_align_unit u_align (
    .funct3_i (req_funct3),
    .write_i  (req_write),
    .lane_i   (lane),
    .wdata_i  (req_wdata),
    .rword_i  (mem_q[word_idx]),
    .be_o     (be),
    .wdata_o  (wdata_sh),
    .err_o    (align_err),
    .rdata_o  (load_ext)
  );

  // FSM state and clear counter register; reset restarts the clear sweep.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next state: sweep every word once, then stay READY.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == IdxW'(NumWords - 1)) state_d = ST_READY;
      end
      default: state_d = ST_READY;
    endcase
  end

  // FSM outputs: clearing blocks requests; READY never backpressures.
  always_comb begin
    req_ready = 1'b0;
    clear_we  = 1'b0;
    case (state_q)
      ST_CLEAR: clear_we  = 1'b1;
      default:  req_ready = 1'b1;
    endcase
  end

  // Storage: clear sweep or byte-enabled store; erroring stores carry no enables.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (accept && req_write) begin
      for (int unsigned b = 0; b < WordBytes; b++) begin
        if (be[b]) mem_q[word_idx][b*BLOCK_SIZE +: BLOCK_SIZE] <= wdata_sh[b*BLOCK_SIZE +: BLOCK_SIZE];
      end
    end
  end

  // Response pipeline; non-load or erroring slots carry zero data so
  // the outputs read 0 whenever nothing valid is presented.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pv_q <= '0;
      pe_q <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) pd_q[i] <= '0;
    end else begin
      pv_q[0] <= accept;
      pe_q[0] <= accept & align_err;
      pd_q[0] <= (accept && !req_write && !align_err) ? load_ext : '0;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  assign rsp_valid = pv_q[READ_LATENCY-1];
  assign rsp_error = pe_q[READ_LATENCY-1];
  assign rsp_rdata = pd_q[READ_LATENCY-1];

endmodule

// File: tb/tb_lsu_data_memory.sv
// Directed bench for lsu_data_memory: a latency-1 and a latency-3 instance
// share one request port; each is checked against hand-computed values.
module tb_lsu_data_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;

  logic        rdy1, vld1, err1;
  logic [31:0] rd1;
  logic        rdy3, vld3, err3;
  logic [31:0] rd3;

  int unsigned cyc = 0;
  int          passed = 0;
  int          total  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lsu_data_memory #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(vld1), .rsp_rdata(rd1), .rsp_error(err1)
  );

  lsu_data_memory #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy3),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(vld3), .rsp_rdata(rd3), .rsp_error(err3)
  );

  typedef struct {
    string       name;
    logic        wr;
    logic [2:0]  f3;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  typedef struct {
    int unsigned cyc;
    logic [31:0] d;
  } exp_t;

  vec_t        vecs[$];
  exp_t        expq[$];
  logic [31:0] model [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic wr, input logic [2:0] f3, input logic [7:0] a, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  task automatic idle();
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 8'h00;
    req_wdata  = 32'h0;
  endtask

  // One request on the latency-1 instance; response is visible right after the accept edge.
  task automatic req1(input logic wr, input logic [2:0] f3, input logic [7:0] a, input logic [31:0] wd,
                      output logic v, output logic [31:0] rd, output logic e);
    drive(wr, f3, a, wd);
    @(posedge clk); #1;
    idle();
    v  = vld1;
    rd = rd1;
    e  = err1;
  endtask

  // Count cycles with req_ready low after reset release; also flag any response strobe.
  task automatic wait_ready(output int n, output int spurious);
    n = 0;
    spurious = 0;
    while (!rdy1 && n < 200) begin
      if (vld1 || vld3 || rdy3) spurious++;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic addv(input string nm, input logic wr, input logic [2:0] f3, input logic [7:0] a,
                      input logic [31:0] wd, input logic [31:0] er, input logic ee);
    vec_t v;
    v.name = nm; v.wr = wr; v.f3 = f3; v.addr = a; v.wd = wd; v.exp_rd = er; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  initial begin
    logic        v, e;
    logic [31:0] rd;
    int          n, sp;

    addv("lw_cleared",  0, 3'b010, 8'h84, 32'h0,        32'h00000000, 0);
    addv("sw_deadbeef", 1, 3'b010, 8'h10, 32'hDEADBEEF, 32'h00000000, 0);
    addv("lb_13",       0, 3'b000, 8'h13, 32'h0,        32'hFFFFFFDE, 0);
    addv("lbu_13",      0, 3'b100, 8'h13, 32'h0,        32'h000000DE, 0);
    addv("lh_12",       0, 3'b001, 8'h12, 32'h0,        32'hFFFFDEAD, 0);
    addv("lhu_10",      0, 3'b101, 8'h10, 32'h0,        32'h0000BEEF, 0);
    addv("lhu_12",      0, 3'b101, 8'h12, 32'h0,        32'h0000DEAD, 0);
    addv("lb_10",       0, 3'b000, 8'h10, 32'h0,        32'hFFFFFFEF, 0);
    addv("lb_11",       0, 3'b000, 8'h11, 32'h0,        32'hFFFFFFBE, 0);
    addv("lw_10",       0, 3'b010, 8'h10, 32'h0,        32'hDEADBEEF, 0);
    addv("sw_11223344", 1, 3'b010, 8'h20, 32'h11223344, 32'h00000000, 0);
    addv("sb_21",       1, 3'b000, 8'h21, 32'hFFFFFFAA, 32'h00000000, 0);
    addv("sh_22",       1, 3'b001, 8'h22, 32'h77775566, 32'h00000000, 0);
    addv("lw_20_merge", 0, 3'b010, 8'h20, 32'h0,        32'h5566AA44, 0);
    addv("lbu_22",      0, 3'b100, 8'h22, 32'h0,        32'h00000066, 0);
    addv("sw_30",       1, 3'b010, 8'h30, 32'h01020304, 32'h00000000, 0);
    addv("sh_31_mis",   1, 3'b001, 8'h31, 32'h0000FFFF, 32'h00000000, 1);
    addv("sbu_illegal", 1, 3'b100, 8'h30, 32'h000000FF, 32'h00000000, 1);
    addv("sw_32_mis",   1, 3'b010, 8'h32, 32'hFFFFFFFF, 32'h00000000, 1);
    addv("lw_30_kept",  0, 3'b010, 8'h30, 32'h0,        32'h01020304, 0);
    addv("lw_02_mis",   0, 3'b010, 8'h02, 32'h0,        32'h00000000, 1);
    addv("ld_f3_011",   0, 3'b011, 8'h00, 32'h0,        32'h00000000, 1);
    addv("lh_13_mis",   0, 3'b001, 8'h13, 32'h0,        32'h00000000, 1);
    addv("lhu_11_mis",  0, 3'b101, 8'h11, 32'h0,        32'h00000000, 1);
    addv("ld_f3_111",   0, 3'b111, 8'h10, 32'h0,        32'h00000000, 1);

    // Reset state
    rst = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready1", {31'h0, rdy1}, 32'h0);
    check("rst_ready3", {31'h0, rdy3}, 32'h0);
    check("rst_valid1", {31'h0, vld1}, 32'h0);
    check("rst_rdata1", rd1, 32'h0);
    check("rst_error1", {31'h0, err1}, 32'h0);
    rst = 1'b1;
    wait_ready(n, sp);
    check("clear_cycles", n, 64);
    check("clear_no_rsp", sp, 0);
    check("ready3_after_clear", {31'h0, rdy3}, 32'h1);

    // Table-driven single requests on the latency-1 instance
    for (int i = 0; i < vecs.size(); i++) begin
      req1(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wd, v, rd, e);
      check({vecs[i].name, "_valid"}, {31'h0, v}, 32'h1);
      check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
      check({vecs[i].name, "_error"}, {31'h0, e}, {31'h0, vecs[i].exp_err});
    end

    // Idle cycle: outputs return to 0
    @(posedge clk); #1;
    check("idle_valid1", {31'h0, vld1}, 32'h0);
    check("idle_rdata1", rd1, 32'h0);

    // Let the latency-3 instance drain before the streaming test
    repeat (4) @(posedge clk);
    #1;

    // Back-to-back SW/LW pairs on the latency-3 instance
    for (int w = 0; w < 64; w++) model[w] = 32'h0;
    fork
      begin
        int unsigned idx, idx2;
        logic [31:0] d;
        exp_t        x;
        for (int p = 0; p < 16; p++) begin
          idx = $urandom_range(32, 63);
          d   = $urandom;
          drive(1'b1, 3'b010, {idx[5:0], 2'b00}, d);
          x.cyc = cyc + 3; x.d = 32'h0;
          expq.push_back(x);
          model[idx] = d;
          @(posedge clk); #1;
          idx2 = (p % 2 == 0) ? idx : $urandom_range(32, 63);
          drive(1'b0, 3'b010, {idx2[5:0], 2'b00}, 32'h0);
          x.cyc = cyc + 3; x.d = model[idx2];
          expq.push_back(x);
          @(posedge clk); #1;
        end
        idle();
      end
      begin
        logic expv;
        for (int k = 0; k < 40; k++) begin
          expv = (expq.size() > 0) && (expq[0].cyc == cyc);
          check("lat3_valid", {31'h0, vld3}, {31'h0, expv});
          if (expv) begin
            if (vld3) begin
              check("lat3_rdata", rd3, expq[0].d);
              check("lat3_error", {31'h0, err3}, 32'h0);
            end
            void'(expq.pop_front());
          end
          @(posedge clk); #1;
        end
      end
    join
    check("lat3_queue_empty", expq.size(), 0);

    // Reset with loads in flight; clear sweep wipes prior data
    req1(1'b1, 3'b010, 8'h40, 32'hCAFEF00D, v, rd, e);
    req1(1'b0, 3'b010, 8'h40, 32'h0, v, rd, e);
    check("cafe_before_rst", rd, 32'hCAFEF00D);
    drive(1'b0, 3'b010, 8'h40, 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 3'b010, 8'h44, 32'h0);
    @(posedge clk); #1;
    idle();
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_valid1", {31'h0, vld1}, 32'h0);
    check("mid_rst_valid3", {31'h0, vld3}, 32'h0);
    check("mid_rst_ready1", {31'h0, rdy1}, 32'h0);
    rst = 1'b1;
    wait_ready(n, sp);
    check("reclear_cycles", n, 64);
    check("reclear_no_rsp", sp, 0);
    req1(1'b0, 3'b010, 8'h40, 32'h0, v, rd, e);
    check("cafe_cleared_valid", {31'h0, v}, 32'h1);
    check("cafe_cleared_rdata", rd, 32'h0);
    check("cafe_cleared_error", {31'h0, e}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
